instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 64'h0, PC of the first instruction fetched after reset.
REQ-002 Parameter BUS_WIDTH, 64, system bus data width in bits.
REQ-003 Parameter LINE_BEATS, 8, bus beats per line (64-byte line, 16 instructions).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 bus_reqcyc  output  1  read request valid.
REQ-007 bus_req  output  64  line-aligned request address.
REQ-008 bus_reqtag  output  13  request tag, READ/MEMORY constant from the shared bus definitions.
REQ-009 bus_reqack  input  1  request accepted.
REQ-010 bus_respcyc  input  1  response beat valid.
REQ-011 bus_resp  input  64  response beat data.
REQ-012 bus_respack  output  1  response beat consumed.
REQ-013 redirect_valid  input  1  taken branch or jump from execute.
REQ-014 redirect_pc  input  64  new fetch PC.
REQ-015 instr_valid  output  1  instruction and cur_pc valid to decoder.
REQ-016 instruction  output  32  instruction word.
REQ-017 cur_pc  output  64  PC of the presented instruction.
REQ-018 instr_ready  input  1  decoder accepts the instruction this cycle.

Function
REQ-019 FSM states: REQ, RESP, SERVE, DRAIN.
REQ-020 REQ: bus_reqcyc=1, bus_req={pc[63:6],6'b0}; bus_req and bus_reqtag stay stable until bus_reqack; on ack go to RESP with beat counter 0.
REQ-021 RESP: bus_respack equals bus_respcyc; each beat is written to buffer[beat]; the counter wraps from LINE_BEATS-1 to 0 and the FSM goes to SERVE.
REQ-022 SERVE: instr_valid=1; instruction = pc[2] ? buffer[pc[5:3]][63:32] : buffer[pc[5:3]][31:0] (little-endian); cur_pc=pc.
REQ-023 On instr_valid&&instr_ready: pc<=pc+4. If the consumed word is at offset pc[5:2]=15, go to REQ next cycle; otherwise stay in SERVE.
REQ-024 Latency: instr_valid rises in the cycle after the final beat is consumed; minimum line-miss latency is 1 (REQ) + LINE_BEATS + 0 cycles.
REQ-025 instr_valid, instruction and cur_pc hold stable while instr_valid && !instr_ready.
REQ-026 Redirect priority: redirect_valid takes priority over instr_ready in the same cycle; the presented instruction is not counted as consumed.
REQ-027 Redirect address: pc<={redirect_pc[63:2],2'b00}; bits [1:0] are ignored.
REQ-028 Redirect in SERVE: go to REQ next cycle and deassert instr_valid; the line is always refetched, with no same-line reuse.
REQ-029 Redirect in REQ before ack: request held unchanged; pending flag set; on ack go to DRAIN.
REQ-030 Redirect in RESP: go to DRAIN.
REQ-031 DRAIN: acknowledge and discard the remaining beats; after the last beat go to REQ with the redirected pc.
REQ-032 Multiple redirects before REQ is re-entered: the last one wins.
REQ-033 instr_valid=0 in every state except SERVE.

Reset
REQ-034 While reset=0: state=REQ; pc=RESET_PC; beat counter=0; pending=0; bus_reqcyc, bus_respack, instr_valid, instruction and cur_pc are all 0; buffer contents are don't-care.
REQ-035 Reset asserted mid-transaction abandons it immediately; after release the first request is for RESET_PC's line.

Structure
REQ-036 fetch_pkg holds the state enum, LINE_BYTES=64, WORDS_PER_LINE=16 and the read tag constant.
REQ-037 The line buffer is the sub-module fetch_line_buffer: LINE_BEATS x BUS_WIDTH, one write port and one 32-bit word-select read port.

Verification
REQ-038 Reset release, RESET_PC=0x1000, 8 beats returned -> bus_req=0x1000; 16 instructions delivered with cur_pc 0x1000..0x103C; then a request for 0x1040.
REQ-039 RESET_PC=0x1038 -> bus_req=0x1000; instructions at 0x1038 and 0x103C only; then a request for 0x1040.
REQ-040 instr_ready held low 5 cycles in SERVE -> outputs stable; pc unchanged.
REQ-041 redirect_pc=0x2006 during beat 3 -> beats 4-7 acknowledged and discarded; next bus_req=0x2000; first cur_pc=0x2004.
REQ-042 redirect_valid and instr_ready both high in SERVE -> next state REQ; redirected pc used; old pc+4 never presented.
REQ-043 reset pulsed low during RESP -> all outputs 0 immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ,
        ST_RESP,
        ST_SERVE,
        ST_DRAIN
    } fetch_state_e;

    localparam int LINE_BYTES     = 64;
    localparam int WORDS_PER_LINE = 16;

    // {READ, MEMORY, 8'h00} as laid out in the shared system-bus tag.
    localparam logic [12:0] TAG_READ_MEMORY = {1'b1, 4'b0001, 8'h00};

endpackage

// File: rtl/fetch_line_buffer.sv
// One-line fetch buffer: beat-wide write port, 32-bit word-select read port.
module fetch_line_buffer #(
    parameter  int LINE_BEATS = 8,
    parameter  int BUS_WIDTH  = 64,
    localparam int AW         = $clog2(LINE_BEATS)
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [BUS_WIDTH-1:0] wdata_i,
    input  logic [AW:0]          raddr_i,
    output logic [31:0]          rdata_o
);

    logic [BUS_WIDTH-1:0] mem_q [LINE_BEATS];
    logic [BUS_WIDTH-1:0] entry;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Little-endian: even word in the low half of the beat.
    assign entry   = mem_q[raddr_i[AW:1]];
    assign rdata_o = raddr_i[0] ? entry[63:32] : entry[31:0];

endmodule

// File: rtl/instr_fetch.sv
// Line-granular instruction fetch: requests a 64-byte line, buffers it,
// then streams its words to the decoder until the line ends or a redirect.
//
//   state    | meaning
//   ST_REQ   | line request on the bus, waiting for ack
//   ST_RESP  | collecting beats into the line buffer
//   ST_SERVE | presenting buffered instructions to decode
//   ST_DRAIN | discarding beats of a line abandoned by a redirect
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          BUS_WIDTH  = 64,
    parameter int          LINE_BEATS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 bus_reqcyc,
    output logic [63:0]          bus_req,
    output logic [12:0]          bus_reqtag,
    input  logic                 bus_reqack,
    input  logic                 bus_respcyc,
    input  logic [BUS_WIDTH-1:0] bus_resp,
    output logic                 bus_respack,
    input  logic                 redirect_valid,
    input  logic [63:0]          redirect_pc,
    output logic                 instr_valid,
    output logic [31:0]          instruction,
    output logic [63:0]          cur_pc,
    input  logic                 instr_ready
);

    localparam int BEAT_W = $clog2(LINE_BEATS);

    fetch_state_e      state_q, state_d;
    logic [63:0]       pc_q, pc_d;
    logic [63:0]       req_pc_q, req_pc_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              pending_q, pending_d;
    logic              buf_we;
    logic              last_beat;
    logic [31:0]       buf_word;
    logic [63:0]       redir_pc;

    assign redir_pc   = redirect_pc & ~64'h3;
    assign last_beat  = bus_respcyc && (beat_q == BEAT_W'(LINE_BEATS - 1));
    assign bus_req    = req_pc_q & ~(64'(LINE_BYTES) - 64'd1);
    assign bus_reqtag = TAG_READ_MEMORY;

    fetch_line_buffer #(
        .LINE_BEATS(LINE_BEATS),
        .BUS_WIDTH (BUS_WIDTH)
    ) u_line_buf (
        .clk    (clk),
        .we_i   (buf_we),
        .waddr_i(beat_q),
        .wdata_i(bus_resp),
        .raddr_i(pc_q[BEAT_W+2:2]),
        .rdata_o(buf_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            req_pc_q  <= RESET_PC;
            beat_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            beat_q    <= beat_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        beat_d      = beat_q;
        pending_d   = pending_q;
        buf_we      = 1'b0;
        bus_reqcyc  = 1'b0;
        bus_respack = 1'b0;
        instr_valid = 1'b0;
        instruction = '0;
        cur_pc      = '0;

        case (state_q)
            ST_REQ: begin
                bus_reqcyc = 1'b1;
                // The request address is held; the redirect only retargets pc.
                if (redirect_valid) begin
                    pc_d      = redir_pc;
                    pending_d = 1'b1;
                end
                if (bus_reqack) begin
                    beat_d    = '0;
                    pending_d = 1'b0;
                    state_d   = (pending_q || redirect_valid) ? ST_DRAIN : ST_RESP;
                end
            end
            ST_RESP: begin
                bus_respack = bus_respcyc;
                buf_we      = bus_respcyc;
                if (bus_respcyc) begin
                    beat_d = beat_q + BEAT_W'(1);
                end
                if (redirect_valid) begin
                    pc_d     = redir_pc;
                    req_pc_d = redir_pc;
                    state_d  = last_beat ? ST_REQ : ST_DRAIN;
                end else if (last_beat) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                instr_valid = 1'b1;
                instruction = buf_word;
                cur_pc      = pc_q;
                if (redirect_valid) begin
                    pc_d     = redir_pc;
                    req_pc_d = redir_pc;
                    state_d  = ST_REQ;
                end else if (instr_ready) begin
                    pc_d = pc_q + 64'd4;
                    if (pc_q[5:2] == 4'(WORDS_PER_LINE - 1)) begin
                        req_pc_d = pc_q + 64'd4;
                        state_d  = ST_REQ;
                    end
                end
            end
            ST_DRAIN: begin
                bus_respack = bus_respcyc;
                if (bus_respcyc) begin
                    beat_d = beat_q + BEAT_W'(1);
                end
                if (redirect_valid) begin
                    pc_d = redir_pc;
                end
                if (last_beat) begin
                    req_pc_d = redirect_valid ? redir_pc : pc_q;
                    state_d  = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        // Outputs drop the moment reset asserts, not at the next edge.
        if (!reset) begin
            bus_reqcyc  = 1'b0;
            bus_respack = 1'b0;
            instr_valid = 1'b0;
            instruction = '0;
            cur_pc      = '0;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; second instance covers a mid-line RESET_PC.
module tb_instr_fetch;

    localparam int LINE_BEATS = 8;

    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;

    logic        bus_reqcyc, bus_respack, instr_valid;
    logic [63:0] bus_req, cur_pc;
    logic [12:0] bus_reqtag;
    logic [31:0] instruction;
    logic        bus_reqack = 1'b0, bus_respcyc = 1'b0, instr_ready = 1'b0;
    logic [63:0] bus_resp = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;

    logic        b_reqcyc, b_respack, b_ivalid;
    logic [63:0] b_req, b_curpc;
    logic [12:0] b_reqtag;
    logic [31:0] b_instr;
    logic        b_reqack = 1'b0, b_respcyc = 1'b0, b_ready = 1'b0;
    logic [63:0] b_resp = '0;
    logic        b_redir_valid = 1'b0;
    logic [63:0] b_redir_pc = '0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(64'h1000), .BUS_WIDTH(64), .LINE_BEATS(LINE_BEATS)) u_dut (
        .clk(clk), .reset(reset),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
        .bus_respack(bus_respack), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instruction(instruction), .cur_pc(cur_pc),
        .instr_ready(instr_ready)
    );

    instr_fetch #(.RESET_PC(64'h1038), .BUS_WIDTH(64), .LINE_BEATS(LINE_BEATS)) u_dut2 (
        .clk(clk), .reset(reset),
        .bus_reqcyc(b_reqcyc), .bus_req(b_req), .bus_reqtag(b_reqtag),
        .bus_reqack(b_reqack), .bus_respcyc(b_respcyc), .bus_resp(b_resp),
        .bus_respack(b_respack), .redirect_valid(b_redir_valid), .redirect_pc(b_redir_pc),
        .instr_valid(b_ivalid), .instruction(b_instr), .cur_pc(b_curpc),
        .instr_ready(b_ready)
    );

    // Memory image: every word is derived from its own byte address.
    function automatic logic [31:0] mw(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ack the pending request and return a full line back-to-back.
    task automatic send_line(input logic [63:0] line, input bit two);
        logic [63:0] beat;
        if (two) b_reqack = 1'b1; else bus_reqack = 1'b1;
        tick();
        b_reqack   = 1'b0;
        bus_reqack = 1'b0;
        for (int k = 0; k < LINE_BEATS; k++) begin
            beat = {mw(line + 64'(8 * k + 4)), mw(line + 64'(8 * k))};
            if (two) begin b_respcyc = 1'b1; b_resp = beat; end
            else     begin bus_respcyc = 1'b1; bus_resp = beat; end
            tick();
        end
        b_respcyc   = 1'b0;
        bus_respcyc = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        checks++;
        if (bus_reqcyc !== 1'b0 || bus_respack !== 1'b0 || instr_valid !== 1'b0 ||
            instruction !== 32'h0 || cur_pc !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: got reqcyc=%b respack=%b valid=%b instr=%h pc=%h expected all zero",
                     bus_reqcyc, bus_respack, instr_valid, instruction, cur_pc);
        end
        checks++;
        if (bus_reqtag !== 13'h1100) begin
            errors++;
            $display("FAIL reqtag: got %h expected %h", bus_reqtag, 13'h1100);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (bus_reqcyc !== 1'b1 || bus_req !== 64'h1000) begin
            errors++;
            $display("FAIL first_request: got reqcyc=%b addr=%h expected 1 / 1000", bus_reqcyc, bus_req);
        end
    endtask

    task automatic test_line_fetch();
        tick();
        tick();
        checks++;
        if (bus_reqcyc !== 1'b1 || bus_req !== 64'h1000) begin
            errors++;
            $display("FAIL req_hold: got reqcyc=%b addr=%h expected 1 / 1000", bus_reqcyc, bus_req);
        end
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0;
        for (int k = 0; k < LINE_BEATS; k++) begin
            bus_respcyc = 1'b1;
            bus_resp    = {mw(64'h1000 + 64'(8 * k + 4)), mw(64'h1000 + 64'(8 * k))};
            #1;
            checks++;
            if (bus_respack !== 1'b1 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL beat_%0d: got respack=%b valid=%b expected 1 / 0", k, bus_respack, instr_valid);
            end
            tick();
        end
        bus_respcyc = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: got valid=%b expected 1 right after final beat", instr_valid);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (instr_valid !== 1'b1 || cur_pc !== 64'h1000 + 64'(4 * i) ||
                instruction !== mw(64'h1000 + 64'(4 * i))) begin
                errors++;
                $display("FAIL stream_%0d: got valid=%b pc=%h instr=%h expected 1 / %h / %h", i,
                         instr_valid, cur_pc, instruction, 64'h1000 + 64'(4 * i), mw(64'h1000 + 64'(4 * i)));
            end
            tick();
        end
        instr_ready = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || bus_reqcyc !== 1'b1 || bus_req !== 64'h1040) begin
            errors++;
            $display("FAIL next_line: got valid=%b reqcyc=%b addr=%h expected 0 / 1 / 1040",
                     instr_valid, bus_reqcyc, bus_req);
        end
    endtask

    task automatic test_stall();
        send_line(64'h1040, 1'b0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (instr_valid !== 1'b1 || cur_pc !== 64'h1044 || instruction !== mw(64'h1044)) begin
                errors++;
                $display("FAIL stall_%0d: got valid=%b pc=%h instr=%h expected 1 / 1044 / %h",
                         i, instr_valid, cur_pc, instruction, mw(64'h1044));
            end
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        #1;
        checks++;
        if (cur_pc !== 64'h1048 || instruction !== mw(64'h1048)) begin
            errors++;
            $display("FAIL stall_release: got pc=%h instr=%h expected 1048 / %h", cur_pc, instruction, mw(64'h1048));
        end
    endtask

    task automatic test_redirect_serve_ready();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1403;
        instr_ready    = 1'b1;
        tick();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || bus_reqcyc !== 1'b1 || bus_req !== 64'h1400) begin
            errors++;
            $display("FAIL redir_serve: got valid=%b reqcyc=%b addr=%h expected 0 / 1 / 1400",
                     instr_valid, bus_reqcyc, bus_req);
        end
        send_line(64'h1400, 1'b0);
        #1;
        checks++;
        if (cur_pc !== 64'h1400 || instruction !== mw(64'h1400)) begin
            errors++;
            $display("FAIL redir_serve_pc: got pc=%h instr=%h expected 1400 / %h", cur_pc, instruction, mw(64'h1400));
        end
    endtask

    task automatic test_redirect_resp();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1800;
        tick();
        redirect_valid = 1'b0;
        bus_reqack     = 1'b1;
        tick();
        bus_reqack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus_respcyc = 1'b1;
            bus_resp    = {mw(64'h1800 + 64'(8 * k + 4)), mw(64'h1800 + 64'(8 * k))};
            if (k == 3) begin
                redirect_valid = 1'b1;
                redirect_pc    = 64'h2006;
            end
            tick();
        end
        redirect_valid = 1'b0;
        for (int k = 4; k < LINE_BEATS; k++) begin
            bus_respcyc = 1'b1;
            bus_resp    = 64'hDEAD_BEEF_DEAD_BEEF;
            #1;
            checks++;
            if (bus_respack !== 1'b1 || instr_valid !== 1'b0 || bus_reqcyc !== 1'b0) begin
                errors++;
                $display("FAIL drain_beat_%0d: got respack=%b valid=%b reqcyc=%b expected 1 / 0 / 0",
                         k, bus_respack, instr_valid, bus_reqcyc);
            end
            tick();
        end
        bus_respcyc = 1'b0;
        #1;
        checks++;
        if (bus_reqcyc !== 1'b1 || bus_req !== 64'h2000) begin
            errors++;
            $display("FAIL drain_req: got reqcyc=%b addr=%h expected 1 / 2000", bus_reqcyc, bus_req);
        end
        send_line(64'h2000, 1'b0);
        #1;
        checks++;
        if (instr_valid !== 1'b1 || cur_pc !== 64'h2004 || instruction !== mw(64'h2004)) begin
            errors++;
            $display("FAIL drain_pc: got valid=%b pc=%h instr=%h expected 1 / 2004 / %h",
                     instr_valid, cur_pc, instruction, mw(64'h2004));
        end
    endtask

    task automatic test_redirect_req();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3000;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h4008;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (bus_reqcyc !== 1'b1 || bus_req !== 64'h3000) begin
            errors++;
            $display("FAIL req_held: got reqcyc=%b addr=%h expected 1 / 3000", bus_reqcyc, bus_req);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h5011;
        tick();
        redirect_valid = 1'b0;
        bus_reqack     = 1'b1;
        tick();
        bus_reqack = 1'b0;
        for (int k = 0; k < LINE_BEATS; k++) begin
            bus_respcyc = 1'b1;
            bus_resp    = 64'h0BAD_0BAD_0BAD_0BAD;
            #1;
            checks++;
            if (bus_respack !== 1'b1 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL pend_drain_%0d: got respack=%b valid=%b expected 1 / 0", k, bus_respack, instr_valid);
            end
            tick();
        end
        bus_respcyc = 1'b0;
        #1;
        checks++;
        if (bus_reqcyc !== 1'b1 || bus_req !== 64'h5000) begin
            errors++;
            $display("FAIL last_wins_req: got reqcyc=%b addr=%h expected 1 / 5000", bus_reqcyc, bus_req);
        end
        send_line(64'h5000, 1'b0);
        #1;
        checks++;
        if (cur_pc !== 64'h5010 || instruction !== mw(64'h5010)) begin
            errors++;
            $display("FAIL last_wins_pc: got pc=%h instr=%h expected 5010 / %h", cur_pc, instruction, mw(64'h5010));
        end
    endtask

    task automatic test_reset_mid();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h6000;
        tick();
        redirect_valid = 1'b0;
        bus_reqack     = 1'b1;
        tick();
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b1;
        bus_resp    = {mw(64'h6004), mw(64'h6000)};
        tick();
        #1;
        checks++;
        if (bus_respack !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_resp: got respack=%b expected 1", bus_respack);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus_respack !== 1'b0 || bus_reqcyc !== 1'b0 || instr_valid !== 1'b0 ||
            cur_pc !== 64'h0 || instruction !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got respack=%b reqcyc=%b valid=%b pc=%h instr=%h expected all zero",
                     bus_respack, bus_reqcyc, instr_valid, cur_pc, instruction);
        end
        bus_respcyc = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        checks++;
        if (bus_reqcyc !== 1'b1 || bus_req !== 64'h1000) begin
            errors++;
            $display("FAIL restart_req: got reqcyc=%b addr=%h expected 1 / 1000", bus_reqcyc, bus_req);
        end
    endtask

    task automatic test_reset_pc_midline();
        checks++;
        if (b_reqcyc !== 1'b1 || b_req !== 64'h1000) begin
            errors++;
            $display("FAIL mid_req: got reqcyc=%b addr=%h expected 1 / 1000", b_reqcyc, b_req);
        end
        send_line(64'h1000, 1'b1);
        b_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (b_ivalid !== 1'b1 || b_curpc !== 64'h1038 + 64'(4 * i) || b_instr !== mw(64'h1038 + 64'(4 * i))) begin
                errors++;
                $display("FAIL mid_stream_%0d: got valid=%b pc=%h instr=%h expected 1 / %h / %h", i,
                         b_ivalid, b_curpc, b_instr, 64'h1038 + 64'(4 * i), mw(64'h1038 + 64'(4 * i)));
            end
            tick();
        end
        b_ready = 1'b0;
        #1;
        checks++;
        if (b_ivalid !== 1'b0 || b_reqcyc !== 1'b1 || b_req !== 64'h1040) begin
            errors++;
            $display("FAIL mid_next: got valid=%b reqcyc=%b addr=%h expected 0 / 1 / 1040", b_ivalid, b_reqcyc, b_req);
        end
    endtask

    initial begin
        test_reset();
        test_line_fetch();
        test_stall();
        test_redirect_serve_ready();
        test_redirect_resp();
        test_redirect_req();
        test_reset_mid();
        test_reset_pc_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
